// File: rtl/io_uart_ctrl_if.sv
// Processor IO port bus plus the byte-wide UART TX/RX handshake between processor and UART.
interface io_uart_ctrl_if;
  logic [7:0] IO_port_ID;
  logic [7:0] IO_write_data;
  logic       IO_write_strobe;
  logic       IO_read_strobe;
  logic [7:0] IO_read_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       irq_rx;

  modport master (
    output IO_port_ID, IO_write_data, IO_write_strobe, IO_read_strobe,
    output tx_ready, rx_data, rx_valid,
    input  IO_read_data, tx_data, tx_valid, irq_rx
  );

  modport slave (
    input  IO_port_ID, IO_write_data, IO_write_strobe, IO_read_strobe,
    input  tx_ready, rx_data, rx_valid,
    output IO_read_data, tx_data, tx_valid, irq_rx
  );
endinterface

// File: rtl/io_uart_ctrl.sv
// IO-port to UART bridge: TX/RX byte FIFOs, status/error ports; strobe edge to tx_valid / rx_valid to irq_rx = 1 cycle.
// Backpressure: tx_ready stalls the TX head; a push into a full FIFO without a same-cycle pop is dropped and flagged.
module io_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] dat_i,
  output logic [W-1:0] dat_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full_o || do_pop);
  assign dat_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= dat_i;
  end
endmodule

module io_uart_ctrl #(
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [7:0] PORT_DATA   = 8'h01,
  parameter logic [7:0] PORT_RXSTAT = 8'h02,
  parameter logic [7:0] PORT_TXSTAT = 8'h03,
  parameter logic [7:0] PORT_ERR    = 8'h04
) (
  input logic            clk100,
  input logic            reset,
  io_uart_ctrl_if.slave  bus
);
  typedef enum logic {RD_IDLE, RD_ACTIVE} rd_state_e;

  rd_state_e  state_q, state_d;
  logic [7:0] rd_port_q, rd_port_d;
  logic       wr_stb_q, rd_stb_q;
  logic       tx_ovf_q, tx_ovf_d;
  logic       rx_ovf_q, rx_ovf_d;

  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic       rx_pop, rx_empty, rx_full;
  logic [7:0] rx_head;
  logic       rd_fall, err_clr;

  assign tx_push = bus.IO_write_strobe && !wr_stb_q && (bus.IO_port_ID == PORT_DATA);
  assign tx_pop  = bus.tx_valid && bus.tx_ready;

  io_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk     (clk100),
    .rst_n   (reset),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .dat_i   (bus.IO_write_data),
    .dat_o   (bus.tx_data),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  io_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk     (clk100),
    .rst_n   (reset),
    .push_i  (bus.rx_valid),
    .pop_i   (rx_pop),
    .dat_i   (bus.rx_data),
    .dat_o   (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  assign bus.tx_valid = !tx_empty;
  assign bus.irq_rx   = !rx_empty;

  // Read side effects fire when the strobe drops, using the port latched at its rise.
  assign rd_fall = (state_q == RD_ACTIVE) && !bus.IO_read_strobe;
  assign rx_pop  = rd_fall && (rd_port_q == PORT_DATA) && !rx_empty;
  assign err_clr = rd_fall && (rd_port_q == PORT_ERR);

  always_comb begin
    state_d   = state_q;
    rd_port_d = rd_port_q;
    case (state_q)
      RD_IDLE: begin
        if (bus.IO_read_strobe && !rd_stb_q) begin
          state_d   = RD_ACTIVE;
          rd_port_d = bus.IO_port_ID;
        end
      end
      RD_ACTIVE: begin
        if (!bus.IO_read_strobe) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // A new overflow on the clearing edge wins over the clear.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    if (err_clr) begin
      tx_ovf_d = 1'b0;
      rx_ovf_d = 1'b0;
    end
    if (tx_push && tx_full && !tx_pop)      tx_ovf_d = 1'b1;
    if (bus.rx_valid && rx_full && !rx_pop) rx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      state_q   <= RD_IDLE;
      rd_port_q <= '0;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_port_q <= rd_port_d;
      wr_stb_q  <= bus.IO_write_strobe;
      rd_stb_q  <= bus.IO_read_strobe;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
    end
  end

  always_comb begin
    bus.IO_read_data = 8'hFF;
    if (bus.IO_read_strobe) begin
      case (bus.IO_port_ID)
        PORT_DATA:   bus.IO_read_data = rx_empty ? 8'h00 : rx_head;
        PORT_RXSTAT: bus.IO_read_data = rx_empty ? 8'h00 : 8'hFF;
        PORT_TXSTAT: bus.IO_read_data = tx_full ? 8'hFF : 8'h00;
        PORT_ERR:    bus.IO_read_data = {6'b0, rx_ovf_q, tx_ovf_q};
        default:     bus.IO_read_data = 8'hFF;
      endcase
    end
  end
endmodule

// File: tb/tb_io_uart_ctrl.sv
// Directed bench for io_uart_ctrl: TX push/drain/overflow, RX read/pop/overflow, error clear, async reset flush.
module tb_io_uart_ctrl;
  logic clk100 = 1'b0;
  logic reset  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  io_uart_ctrl_if u_if ();

  io_uart_ctrl dut (
    .clk100 (clk100),
    .reset  (reset),
    .bus    (u_if.slave)
  );

  always #5 clk100 = ~clk100;

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] dat);
    u_if.IO_port_ID      = port;
    u_if.IO_write_data   = dat;
    u_if.IO_write_strobe = 1'b1;
    tick();
    u_if.IO_write_strobe = 1'b0;
    tick();
  endtask

  task automatic io_read(input logic [7:0] port, input logic [7:0] exp, input string tag);
    u_if.IO_port_ID     = port;
    u_if.IO_read_strobe = 1'b1;
    #1;
    check(tag, u_if.IO_read_data, exp);
    tick();
    u_if.IO_read_strobe = 1'b0;
    tick();
  endtask

  task automatic rx_pulse(input logic [7:0] dat);
    u_if.rx_data  = dat;
    u_if.rx_valid = 1'b1;
    tick();
    u_if.rx_valid = 1'b0;
  endtask

  initial begin
    u_if.IO_port_ID      = 8'h00;
    u_if.IO_write_data   = 8'h00;
    u_if.IO_write_strobe = 1'b0;
    u_if.IO_read_strobe  = 1'b0;
    u_if.tx_ready        = 1'b0;
    u_if.rx_data         = 8'h00;
    u_if.rx_valid        = 1'b0;

    #2;
    check("rst_tx_valid", {7'b0, u_if.tx_valid}, 8'h00);
    check("rst_tx_data", u_if.tx_data, 8'h00);
    check("rst_irq_rx", {7'b0, u_if.irq_rx}, 8'h00);
    check("rst_rd_data", u_if.IO_read_data, 8'hFF);
    reset = 1'b1;
    tick();

    // Single push from a strobe held three cycles
    u_if.IO_port_ID      = 8'h01;
    u_if.IO_write_data   = 8'hA5;
    u_if.IO_write_strobe = 1'b1;
    tick();
    check("wr_tx_valid", {7'b0, u_if.tx_valid}, 8'h01);
    check("wr_tx_data", u_if.tx_data, 8'hA5);
    tick();
    tick();
    u_if.IO_write_strobe = 1'b0;
    tick();
    check("wr_hold_data", u_if.tx_data, 8'hA5);
    io_read(8'h03, 8'h00, "txstat_one");
    u_if.tx_ready = 1'b1;
    tick();
    u_if.tx_ready = 1'b0;
    check("wr_single_entry", {7'b0, u_if.tx_valid}, 8'h00);

    // Write to a non-data port is ignored
    io_write(8'h02, 8'h77);
    check("wr_other_port", {7'b0, u_if.tx_valid}, 8'h00);

    // TX fill, overflow and ordered drain
    for (int i = 0; i < 8; i++) io_write(8'h01, 8'(i));
    io_read(8'h03, 8'hFF, "txstat_full");
    io_write(8'h01, 8'h08);
    io_read(8'h04, 8'h01, "tx_overflow");
    u_if.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tx_drain_%0d", i), u_if.tx_data, 8'(i));
      tick();
    end
    u_if.tx_ready = 1'b0;
    check("tx_drained", {7'b0, u_if.tx_valid}, 8'h00);
    io_read(8'h04, 8'h00, "err_cleared_tx");

    // RX ordering and pop on strobe fall
    rx_pulse(8'h3C);
    check("irq_latency", {7'b0, u_if.irq_rx}, 8'h01);
    rx_pulse(8'h7E);
    io_read(8'h02, 8'hFF, "rxstat_full");
    io_read(8'h01, 8'h3C, "rx_first");
    io_read(8'h01, 8'h7E, "rx_second");
    io_read(8'h02, 8'h00, "rxstat_empty");
    check("irq_clear", {7'b0, u_if.irq_rx}, 8'h00);

    // RX full with push on the same edge as a pop
    for (int i = 0; i < 8; i++) rx_pulse(8'h10 + 8'(i));
    io_read(8'h02, 8'hFF, "rx_filled");
    u_if.IO_port_ID     = 8'h01;
    u_if.IO_read_strobe = 1'b1;
    #1;
    check("rx_head_full", u_if.IO_read_data, 8'h10);
    tick();
    u_if.IO_read_strobe = 1'b0;
    u_if.rx_data        = 8'h18;
    u_if.rx_valid       = 1'b1;
    tick();
    u_if.rx_valid = 1'b0;
    io_read(8'h04, 8'h00, "rx_pop_push_no_ovf");
    rx_pulse(8'h19);
    io_read(8'h04, 8'h02, "rx_overflow");
    io_read(8'h04, 8'h00, "err_cleared_rx");

    // Unmapped port: no side effect on RX head
    io_read(8'h55, 8'hFF, "unmapped");
    for (int i = 0; i < 8; i++)
      io_read(8'h01, 8'h11 + 8'(i), $sformatf("rx_drain_%0d", i));
    io_read(8'h01, 8'h00, "rx_empty_read");
    io_read(8'h04, 8'h00, "empty_pop_no_flag");

    // Latched port survives an ID change while the strobe is high
    rx_pulse(8'h5A);
    u_if.IO_port_ID     = 8'h01;
    u_if.IO_read_strobe = 1'b1;
    tick();
    u_if.IO_port_ID = 8'h55;
    tick();
    u_if.IO_read_strobe = 1'b0;
    tick();
    check("latched_port_pop", {7'b0, u_if.irq_rx}, 8'h00);

    // Asynchronous reset with traffic queued
    for (int i = 0; i < 4; i++) io_write(8'h01, 8'hC0 + 8'(i));
    for (int i = 0; i < 3; i++) rx_pulse(8'hD0 + 8'(i));
    check("pre_rst_tx_valid", {7'b0, u_if.tx_valid}, 8'h01);
    check("pre_rst_irq", {7'b0, u_if.irq_rx}, 8'h01);
    reset = 1'b0;
    #2;
    check("async_tx_valid", {7'b0, u_if.tx_valid}, 8'h00);
    check("async_irq_rx", {7'b0, u_if.irq_rx}, 8'h00);
    check("async_tx_data", u_if.tx_data, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    io_read(8'h02, 8'h00, "post_rst_rxstat");
    io_read(8'h04, 8'h00, "post_rst_err");
    check("post_rst_tx_valid", {7'b0, u_if.tx_valid}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
